// File: rtl/imem_responder.sv
// SueRV32 instruction-memory responder: word-addressed store, fixed wait states, valid/ready fetch port.
// Define IMEM_MISALIGN_FAULT_EN to fault requests whose req_addr[1:0] != 0.
module imem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_addr,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [31:0]                    resp_instr,
    output logic                           resp_fault,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [31:0]                    ld_data
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [AW-1:0] idx_q;
    logic          fault_q;
    logic          accept;
    logic          oor;
    logic          addr_fault;
    logic          rd_edge;
    logic [31:0]   mem [DEPTH_WORDS];

    assign req_ready  = rstn && (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign oor        = |(req_addr >> (AW + 2));

`ifdef IMEM_MISALIGN_FAULT_EN
    assign addr_fault = oor || (req_addr[1:0] != 2'b00);
`else
    assign addr_fault = oor;
`endif

    // Counter is loaded with WAIT_CYCLES so WAIT also covers the address-latch
    // cycle; RESP is therefore entered WAIT_CYCLES+1 edges after acceptance.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (accept) begin
                state_nxt = WAIT;
                cnt_nxt   = 4'(WAIT_CYCLES);
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RESP: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_edge = (state == WAIT) && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_instr <= 32'h0000_0000;
            resp_fault <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (rd_edge) begin
                resp_fault <= fault_q;
                // A boot-load write to the same word on this edge wins over the stale store value.
                if (fault_q)                          resp_instr <= NOP;
                else if (ld_en && (ld_addr == idx_q)) resp_instr <= ld_data;
                else                                  resp_instr <= mem[idx_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= req_addr[AW+1:2];
            fault_q <= addr_fault;
        end
    end

    // Store has no reset so boot-loaded code survives a core reset.
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end
endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances with WAIT_CYCLES = 0, 1, 3 sharing the load bus.
module tb_imem_responder;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          rv [3];
    logic          rr [3];
    logic [31:0]   ra [3];
    logic          qr [3];
    logic          sv [3];
    logic          sf [3];
    logic [31:0]   si [3];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rstn(rstn), .req_valid(rv[0]), .req_ready(qr[0]), .req_addr(ra[0]),
        .resp_valid(sv[0]), .resp_ready(rr[0]), .resp_instr(si[0]), .resp_fault(sf[0]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));
    imem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u1 (
        .clk(clk), .rstn(rstn), .req_valid(rv[1]), .req_ready(qr[1]), .req_addr(ra[1]),
        .resp_valid(sv[1]), .resp_ready(rr[1]), .resp_instr(si[1]), .resp_fault(sf[1]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));
    imem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .rstn(rstn), .req_valid(rv[2]), .req_ready(qr[2]), .req_addr(ra[2]),
        .resp_valid(sv[2]), .resp_ready(rr[2]), .resp_instr(si[2]), .resp_fault(sf[2]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic load(input int a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = AW'(a); ld_data = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    // Issue one request on instance k; returns edges from acceptance to resp_valid.
    task automatic xact(input int k, input logic [31:0] addr,
                        output int lat, output logic [31:0] ins, output logic flt);
        @(negedge clk);
        chk($sformatf("req_ready[%0d] idle", k), 32'(qr[k]), 32'd1);
        rv[k] = 1'b1; ra[k] = addr;
        @(posedge clk);
        @(negedge clk);
        rv[k] = 1'b0;
        lat = 0;
        while (!sv[k] && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        ins = si[k];
        flt = sf[k];
    endtask

    logic [31:0] w [8];
    vec_t        tv [8];

    initial begin
        int          lat;
        logic [31:0] ins, held;
        logic        flt;
        bit          saw;
        int          acc [3], rsp [3];
        logic [31:0] rdat [3];
        int          na, nr;

        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b0; rr[i] = 1'b1; ra[i] = 32'h0;
        end
        ld_en = 1'b0; ld_addr = '0; ld_data = 32'h0;
        for (int i = 0; i < 8; i++) w[i] = 32'h1000_0000 | (32'(i) << 8) | 32'(i);
        w[4] = 32'h00A0_0093;

        tv[0] = '{32'h0000_0010, 32'h00A0_0093, 1'b0};
        tv[1] = '{32'h0000_0000, w[0],          1'b0};
        tv[2] = '{32'h0000_001C, w[7],          1'b0};
        tv[3] = '{32'h0000_0FFC, 32'h0BAD_F00D, 1'b0};
        tv[4] = '{32'h0000_1000, 32'h0000_0013, 1'b1};
        tv[5] = '{32'h8000_0004, 32'h0000_0013, 1'b1};
`ifdef IMEM_MISALIGN_FAULT_EN
        tv[6] = '{32'h0000_0012, 32'h0000_0013, 1'b1};
`else
        tv[6] = '{32'h0000_0012, 32'h00A0_0093, 1'b0};
`endif
        tv[7] = '{32'h0000_0008, w[2],          1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst req_ready", 32'(qr[1]), 32'd0);
        chk("rst resp_valid", 32'(sv[1]), 32'd0);
        chk("rst resp_fault", 32'(sf[1]), 32'd0);
        chk("rst resp_instr", si[1], 32'h0);
        chk("rst resp_instr w3", si[2], 32'h0);
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("req_ready after release", 32'(qr[1]), 32'd1);

        for (int i = 0; i < 8; i++) load(i, w[i]);
        load(1023, 32'h0BAD_F00D);

        // Table-driven reads, WAIT_CYCLES = 1
        for (int i = 0; i < 8; i++) begin
            xact(1, tv[i].addr, lat, ins, flt);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
            chk($sformatf("vec%0d instr", i), ins, tv[i].instr);
            chk($sformatf("vec%0d fault", i), 32'(flt), 32'(tv[i].fault));
        end

        // Backpressure: hold resp_ready low for 5 cycles
        @(posedge clk);
        #1 rr[1] = 1'b0;
        xact(1, 32'h0000_001C, lat, held, flt);
        chk("bp instr", held, w[7]);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp%0d resp_valid", c), 32'(sv[1]), 32'd1);
            chk($sformatf("bp%0d resp_instr", c), si[1], w[7]);
            chk($sformatf("bp%0d req_ready", c), 32'(qr[1]), 32'd0);
        end
        rr[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp release req_ready", 32'(qr[1]), 32'd1);
        chk("bp release resp_valid", 32'(sv[1]), 32'd0);

        // Write-forward on the RESP-entry edge, WAIT_CYCLES = 3
        @(negedge clk);
        rv[2] = 1'b1; ra[2] = 32'h0000_0010;
        @(posedge clk);
        @(negedge clk);
        rv[2] = 1'b0;
        repeat (3) @(negedge clk);
        chk("fwd resp_valid early", 32'(sv[2]), 32'd0);
        ld_en = 1'b1; ld_addr = AW'(4); ld_data = 32'hDEAD_BEEF;
        @(negedge clk);
        ld_en = 1'b0;
        chk("fwd resp_valid", 32'(sv[2]), 32'd1);
        chk("fwd instr", si[2], 32'hDEAD_BEEF);
        chk("fwd fault", 32'(sf[2]), 32'd0);

        // Reset during WAIT aborts the request
        @(negedge clk);
        rv[2] = 1'b1; ra[2] = 32'h0000_0010;
        @(posedge clk);
        @(negedge clk);
        rv[2] = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort req_ready in reset", 32'(qr[2]), 32'd0);
        chk("abort resp_valid in reset", 32'(sv[2]), 32'd0);
        rstn = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 0) chk("abort req_ready after release", 32'(qr[2]), 32'd1);
            if (sv[2]) saw = 1'b1;
        end
        chk("abort no response", 32'(saw), 32'd0);
        xact(2, 32'h0000_0010, lat, ins, flt);
        chk("post-reset latency", 32'(lat), 32'd4);
        chk("post-reset word4", ins, 32'hDEAD_BEEF);

        // Back-to-back, WAIT_CYCLES = 0
        @(posedge clk);
        na = 0; nr = 0;
        for (int i = 0; i < 3; i++) begin
            acc[i] = -100; rsp[i] = 0; rdat[i] = 32'h0;
        end
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (sv[0] && nr < 3) begin
                rsp[nr] = c; rdat[nr] = si[0]; nr++;
            end
            rv[0] = (na < 3);
            ra[0] = 32'(na) * 32'd4;
            if (rv[0] && qr[0]) begin
                acc[na] = c; na++;
            end
        end
        rv[0] = 1'b0;
        chk("b2b responses", 32'(nr), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b2b%0d latency", i), 32'(rsp[i] - 1 - acc[i]), 32'd1);
            chk($sformatf("b2b%0d instr", i), rdat[i], w[i]);
        end
        chk("b2b period01", 32'(acc[1] - acc[0]), 32'd3);
        chk("b2b period12", 32'(acc[2] - acc[1]), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the SueRV32 fetch stage. It accepts fetch requests carrying a program-counter address, reads a word-addressed instruction store, and returns the 32-bit instruction after a configurable number of wait states through a valid/ready handshake. A boot-load write port fills the store. The address space starts at 0x0000_0000, matching the PC reset value.

## Interface
Parameters:
- DEPTH_WORDS, 1024: instruction store size in 32-bit words; must be a power of two, ≥ 2. AW = $clog2(DEPTH_WORDS).
- WAIT_CYCLES, 1: wait states between request acceptance and response; legal range 0–15.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  synchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address from the PC.
- resp_valid  out  1  response valid.
- resp_ready  in  1  fetch stage accepts the response.
- resp_instr  out  32  fetched instruction.
- resp_fault  out  1  address fault flag, qualified by resp_valid.
- ld_en  in  1  boot-load write enable.
- ld_addr  in  AW  boot-load word index.
- ld_data  in  32  boot-load write data.

## Operation
- FSM states are IDLE, WAIT and RESP. One request is in flight at most; there is no pipelining.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch req_addr and compute the fault status.
  - If WAIT_CYCLES = 0, go to RESP. Otherwise go to WAIT with the wait counter set to WAIT_CYCLES − 1.
- WAIT:
  - req_ready = 0.
  - Decrement the counter each cycle. When the counter is 0, go to RESP.
- RESP:
  - resp_valid = 1; resp_instr and resp_fault are held stable.
  - On resp_ready, go to IDLE. A new request can be accepted on the next cycle only; there is no same-cycle turnaround.
- Read sampling:
  - The store is read on the edge that enters RESP, and resp_instr is registered.
  - If ld_en writes the latched word index on that same edge, the new ld_data is returned (write-forwarding).
- Address decode:
  - Word index = req_addr[AW+1:2].
  - Out of range: any bit of req_addr[31:AW+2] is set. The response is resp_fault = 1 and resp_instr = 0x0000_0013 (NOP).
- Store writes: ld_en writes in any state, one word per cycle.
- Arithmetic: the wait counter is 4 bits and never underflows.

## Timing
- Reset values (cycle after rstn sampled low):
  - State = IDLE, resp_valid = 0, resp_fault = 0, resp_instr = 0x0000_0000, wait counter = 0.
  - req_ready is 0 while rstn is low and 1 in the first cycle after release.
- Reset mid-operation aborts any pending request, with no response. Store contents are preserved across reset.
- Latency: request accepted at edge N gives resp_valid = 1 from edge N + WAIT_CYCLES + 1.
- Throughput: at best one instruction every WAIT_CYCLES + 3 cycles.
- Backpressure: resp_valid stays 1 and the data stays stable for as long as resp_ready = 0.
- req_valid while in WAIT or RESP is ignored (not latched). The requester must hold req_valid until req_ready.
- Store is uninitialised until written. The bench writes every word it reads.

## Configuration
- IMEM_MISALIGN_FAULT_EN defined:
  - In range with req_addr[1:0] ≠ 0: resp_fault = 1, resp_instr = 0x0000_0013.
  - Fault takes priority; the store is not read for the returned data.
- IMEM_MISALIGN_FAULT_EN undefined:
  - req_addr[1:0] is ignored and the aligned word is returned.
  - resp_fault reflects only the out-of-range condition.

## Test plan
- Basic read, WAIT_CYCLES = 1: load word 4 = 0x00A0_0093, request 0x0000_0010 → resp_valid 2 cycles after acceptance, resp_instr = 0x00A0_0093, resp_fault = 0.
- Backpressure: hold resp_ready = 0 for 5 cycles → resp_valid and resp_instr stay constant, req_ready = 0; the cycle after resp_ready = 1, req_ready = 1.
- Out of range, DEPTH_WORDS = 1024: request 0x0000_1000 → resp_fault = 1, resp_instr = 0x0000_0013.
- Misalign: request 0x0000_0012.
  - With IMEM_MISALIGN_FAULT_EN: resp_fault = 1, resp_instr = 0x0000_0013.
  - Without it: word 4 is returned, resp_fault = 0.
- Write-forward and reset, WAIT_CYCLES = 3:
  - ld_en to word 4 with 0xDEAD_BEEF on the RESP-entry edge → 0xDEAD_BEEF is returned.
  - Repeat the request and drop rstn during WAIT → no response, resp_valid = 0, req_ready = 1 after release. Word 4 still reads 0xDEAD_BEEF.
- WAIT_CYCLES = 0: back-to-back requests at 0x0, 0x4, 0x8 with resp_ready = 1 → each response 1 cycle after acceptance, 3 cycles per instruction.
